// File: rtl/seq_flag_monitor.sv
// rtl/seq_flag_monitor.sv - sequencer status-flag checker: z3 run length, z2 count, sticky coded alarm.
// Optional alarm timestamp (alarm_stamp, mon_cycles) is built when SEQ_MON_STAMP_EN is defined.
module seq_flag_monitor #(
  parameter int CNT_W     = 8,
  parameter int RUN_MAX   = 4,
  parameter int ARM_DELAY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             z1,
  input  logic             z2,
  input  logic             z3,
  output logic             alarm,
  output logic [1:0]       alarm_code,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] z2_cnt,
  output logic             busy
`ifdef SEQ_MON_STAMP_EN
  ,
  output logic [CNT_W-1:0] alarm_stamp
`endif
);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_MON   = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  localparam state_t ST_INIT = (ARM_DELAY == 0) ? ST_MON : ST_WAIT;

  // The arm counter only needs to reach ARM_DELAY-1 before the WAIT->MON hop.
  localparam int ARM_W = (ARM_DELAY < 2) ? 1 : $clog2(ARM_DELAY);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_DELAY - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_MAX);

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_Z1   = 2'b01;
  localparam logic [1:0] CODE_RUN  = 2'b10;
  localparam logic [1:0] CODE_Z2   = 2'b11;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [ARM_W-1:0]   arm_q, arm_d;
  logic               alarm_q, alarm_d;
  logic [1:0]         code_q, code_d;
  logic [CNT_W-1:0]   run_len_q, run_len_d;
  logic [CNT_W-1:0]   z2_cnt_q, z2_cnt_d;
  logic [1:0]         viol_code;
`ifdef SEQ_MON_STAMP_EN
  logic [CNT_W-1:0]   mon_cycles_q, mon_cycles_d;
  logic [CNT_W-1:0]   stamp_q, stamp_d;
`endif

  // Priority encoder: z1 beats run overflow beats orphan z2.
  always_comb begin
    viol_code = CODE_NONE;
    if (z1) begin
      viol_code = CODE_Z1;
    end else if (z3 && (run_len_q == RUN_LIM)) begin
      viol_code = CODE_RUN;
    end else if (z2 && !z3) begin
      viol_code = CODE_Z2;
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    alarm_d   = alarm_q;
    code_d    = code_q;
    run_len_d = run_len_q;
    z2_cnt_d  = z2_cnt_q;
`ifdef SEQ_MON_STAMP_EN
    mon_cycles_d = mon_cycles_q;
    stamp_d      = stamp_q;
`endif
    if (clr) begin
      state_d   = ST_INIT;
      arm_d     = '0;
      alarm_d   = 1'b0;
      code_d    = CODE_NONE;
      run_len_d = '0;
      z2_cnt_d  = '0;
`ifdef SEQ_MON_STAMP_EN
      mon_cycles_d = '0;
      stamp_d      = '0;
`endif
    end else if (en) begin
      case (state_q)
        ST_WAIT: begin
          if (arm_q == ARM_LAST) begin
            state_d = ST_MON;
            arm_d   = '0;
          end else begin
            arm_d = arm_q + 1'b1;
          end
        end
        ST_MON: begin
          run_len_d = z3 ? sat_inc(run_len_q) : '0;
          z2_cnt_d  = z2 ? sat_inc(z2_cnt_q) : z2_cnt_q;
`ifdef SEQ_MON_STAMP_EN
          mon_cycles_d = sat_inc(mon_cycles_q);
`endif
          if (viol_code != CODE_NONE) begin
            state_d = ST_ALARM;
            alarm_d = 1'b1;
            code_d  = viol_code;
`ifdef SEQ_MON_STAMP_EN
            stamp_d = sat_inc(mon_cycles_q);
`endif
          end
        end
        default: begin
          // ALARM: everything frozen until clr or reset.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      arm_q     <= '0;
      alarm_q   <= 1'b0;
      code_q    <= CODE_NONE;
      run_len_q <= '0;
      z2_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      alarm_q   <= alarm_d;
      code_q    <= code_d;
      run_len_q <= run_len_d;
      z2_cnt_q  <= z2_cnt_d;
    end
  end

`ifdef SEQ_MON_STAMP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mon_cycles_q <= '0;
      stamp_q      <= '0;
    end else begin
      mon_cycles_q <= mon_cycles_d;
      stamp_q      <= stamp_d;
    end
  end

  assign alarm_stamp = stamp_q;
`endif

  assign alarm      = alarm_q;
  assign alarm_code = code_q;
  assign run_len    = run_len_q;
  assign z2_cnt     = z2_cnt_q;
  assign busy       = (state_q == ST_WAIT);

endmodule
